// File: rtl/rotdc_pkg.sv
// Shared definitions for the ring-oscillator TDC measurement sequencer:
// state encoding and default widths used by the core, CSR block and sequencer.
package rotdc_pkg;

    localparam int DEF_COUNTER_LEN = 64;
    localparam int DEF_FINE_W      = 8;
    localparam int DEF_TIMEOUT_W   = 16;
    localparam int DEF_WARM_CYC    = 8;
    localparam int DEF_SETTLE_CYC  = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WARM    = 3'd1,
        S_ARMED   = 3'd2,
        S_RUN     = 3'd3,
        S_SETTLE  = 3'd4,
        S_CAPTURE = 3'd5,
        S_HOLD    = 3'd6
    } rotdc_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rotdc_cycle_timer.sv
// Loadable down-counter shared by the warm-up, settle and timeout intervals.
// Load takes priority over decrement; zero reflects the current count.
module rotdc_cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rotdc_seq.sv
// Measurement sequencer: warms the ring, arms the TDC core, waits for start/stop
// with an optional timeout, and presents the wrap-safe interval on a valid/ready port.
module rotdc_seq
    import rotdc_pkg::*;
#(
    parameter int COUNTER_LEN = DEF_COUNTER_LEN,
    parameter int FINE_W      = DEF_FINE_W,
    parameter int TIMEOUT_W   = DEF_TIMEOUT_W,
    parameter int WARM_CYC    = DEF_WARM_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   meas_req,
    input  logic                   abort,
    input  logic [TIMEOUT_W-1:0]   timeout_cyc,
    output logic                   meas_busy,
    output logic                   ro_en,
    output logic                   tdc_arm,
    input  logic                   start_flag,
    input  logic                   stop_flag,
    input  logic [COUNTER_LEN-1:0] start_coarse,
    input  logic [COUNTER_LEN-1:0] stop_coarse,
    input  logic [FINE_W-1:0]      start_fine,
    input  logic [FINE_W-1:0]      stop_fine,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [COUNTER_LEN-1:0] res_coarse,
    output logic [FINE_W-1:0]      res_start_fine,
    output logic [FINE_W-1:0]      res_stop_fine,
    output logic                   res_timeout,
    output rotdc_state_t           dbg_state
);

    // Result handshake: a record transfers on a cycle where res_valid and res_ready
    // are both high; while res_valid is high the record is held stable.
    localparam int TMR_W = max_int(TIMEOUT_W,
                                   max_int($clog2(WARM_CYC + 1), $clog2(SETTLE_CYC + 1)));

    rotdc_state_t     state, next_state;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic             to_take, to_en, to_hit;

    rotdc_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Intervals load N-1 so that zero is seen on the last cycle of the interval.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;
        to_take    = 1'b0;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (meas_req) begin
                        next_state = S_WARM;
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(WARM_CYC - 1);
                    end
                end
                S_WARM: begin
                    if (tmr_zero) begin
                        next_state = S_ARMED;
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(timeout_cyc - TIMEOUT_W'(1));
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                S_ARMED, S_RUN: begin
                    tmr_dec = 1'b1;
                    // A stop before any start is noise and must not end the measurement.
                    if (stop_flag && (start_flag || state == S_RUN)) begin
                        next_state = S_SETTLE;
                        tmr_load   = 1'b1;
                        tmr_val    = TMR_W'(SETTLE_CYC - 1);
                    end else if (to_en && tmr_zero) begin
                        next_state = S_CAPTURE;
                        to_take    = 1'b1;
                    end else if (state == S_ARMED && start_flag) begin
                        next_state = S_RUN;
                    end
                end
                S_SETTLE: begin
                    if (tmr_zero) begin
                        next_state = S_CAPTURE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                S_CAPTURE: next_state = S_HOLD;
                S_HOLD: begin
                    if (res_ready) begin
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            to_en          <= 1'b0;
            to_hit         <= 1'b0;
            meas_busy      <= 1'b0;
            ro_en          <= 1'b0;
            tdc_arm        <= 1'b0;
            res_valid      <= 1'b0;
            res_coarse     <= '0;
            res_start_fine <= '0;
            res_stop_fine  <= '0;
            res_timeout    <= 1'b0;
        end else begin
            state     <= next_state;
            meas_busy <= (next_state != S_IDLE);
            ro_en     <= next_state inside {S_WARM, S_ARMED, S_RUN, S_SETTLE};
            tdc_arm   <= next_state inside {S_ARMED, S_RUN};
            res_valid <= (next_state == S_HOLD);
            if (state == S_WARM && next_state == S_ARMED) begin
                to_en <= (timeout_cyc != '0);
            end
            if (next_state == S_IDLE) begin
                to_hit <= 1'b0;
            end else if (to_take) begin
                to_hit <= 1'b1;
            end
            // Leaving for IDLE (accept or abort) wipes the record so IDLE outputs are all zero.
            if (next_state == S_IDLE) begin
                res_coarse     <= '0;
                res_start_fine <= '0;
                res_stop_fine  <= '0;
                res_timeout    <= 1'b0;
            end else if (state == S_CAPTURE) begin
                if (to_hit) begin
                    res_coarse     <= '0;
                    res_start_fine <= '0;
                    res_stop_fine  <= '0;
                    res_timeout    <= 1'b1;
                end else begin
                    res_coarse     <= stop_coarse - start_coarse;
                    res_start_fine <= start_fine;
                    res_stop_fine  <= stop_fine;
                    res_timeout    <= 1'b0;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rotdc_seq.sv
// Self-checking bench for rotdc_seq: directed and randomized measurements checked
// against cycle-count and modular-arithmetic expectations derived from the block's rules.
module tb_rotdc_seq;
    import rotdc_pkg::*;

    localparam int CL     = 64;
    localparam int FW     = 8;
    localparam int TW     = 16;
    localparam int WARM   = 8;
    localparam int SETTLE = 2;

    logic          clk;
    logic          rst_n;
    logic          meas_req;
    logic          abort;
    logic [TW-1:0] timeout_cyc;
    logic          meas_busy;
    logic          ro_en;
    logic          tdc_arm;
    logic          start_flag;
    logic          stop_flag;
    logic [CL-1:0] start_coarse;
    logic [CL-1:0] stop_coarse;
    logic [FW-1:0] start_fine;
    logic [FW-1:0] stop_fine;
    logic          res_valid;
    logic          res_ready;
    logic [CL-1:0] res_coarse;
    logic [FW-1:0] res_start_fine;
    logic [FW-1:0] res_stop_fine;
    logic          res_timeout;
    rotdc_state_t  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    rotdc_seq #(
        .COUNTER_LEN (CL),
        .FINE_W      (FW),
        .TIMEOUT_W   (TW),
        .WARM_CYC    (WARM),
        .SETTLE_CYC  (SETTLE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .meas_req       (meas_req),
        .abort          (abort),
        .timeout_cyc    (timeout_cyc),
        .meas_busy      (meas_busy),
        .ro_en          (ro_en),
        .tdc_arm        (tdc_arm),
        .start_flag     (start_flag),
        .stop_flag      (stop_flag),
        .start_coarse   (start_coarse),
        .stop_coarse    (stop_coarse),
        .start_fine     (start_fine),
        .stop_fine      (stop_fine),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_coarse     (res_coarse),
        .res_start_fine (res_start_fine),
        .res_stop_fine  (res_stop_fine),
        .res_timeout    (res_timeout),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  64'(meas_busy),  64'd0);
        chk({tag, ".ro_en"}, 64'(ro_en),      64'd0);
        chk({tag, ".arm"},   64'(tdc_arm),    64'd0);
        chk({tag, ".valid"}, 64'(res_valid),  64'd0);
        chk({tag, ".coarse"}, 64'(res_coarse), 64'd0);
    endtask

    // One full measurement. Relative cycle 0 is the first cycle in ARMED; inputs
    // changed in relative cycle r are sampled at relative edge r+1.
    task automatic do_meas(input string tag, input logic [63:0] sc, input logic [63:0] ec,
                           input logic [7:0] sf, input logic [7:0] ef, input int start_dly,
                           input int stop_dly, input logic [15:0] t, input bit stray_stop,
                           input int bp_cyc);
        int m, exp_rel, rel;
        bit exp_to, seen;
        logic [63:0] exp_coarse;
        logic [7:0]  exp_sf, exp_ef;

        m = (stop_dly < 0) ? -1 : start_dly + stop_dly + 1;
        if (m >= 0 && (t == 16'd0 || m <= int'(t))) begin
            exp_to     = 1'b0;
            exp_rel    = m + SETTLE + 1;
            exp_coarse = ec - sc;
            exp_sf     = sf;
            exp_ef     = ef;
        end else begin
            exp_to     = 1'b1;
            exp_rel    = int'(t) + 1;
            exp_coarse = 64'd0;
            exp_sf     = 8'd0;
            exp_ef     = 8'd0;
        end

        timeout_cyc = t;
        meas_req    = 1'b1;
        tick();
        meas_req = 1'b0;
        chk({tag, ".warm_busy"}, 64'(meas_busy), 64'd1);
        chk({tag, ".warm_ro"},   64'(ro_en),     64'd1);
        repeat (WARM - 1) tick();
        chk({tag, ".warm_arm0"}, 64'(tdc_arm), 64'd0);
        tick();
        chk({tag, ".armed"}, 64'(tdc_arm), 64'd1);

        rel  = 0;
        seen = 1'b0;
        while (!seen && rel < 400) begin
            if (stray_stop && rel <= 1) begin
                stop_flag   = (rel == 0);
                stop_coarse = ~ec;
            end
            if (rel == start_dly) begin
                start_flag   = 1'b1;
                start_coarse = sc;
                start_fine   = sf;
            end
            if (stop_dly >= 0 && rel == start_dly + stop_dly) begin
                stop_flag   = 1'b1;
                stop_coarse = ec;
                stop_fine   = ef;
            end
            tick();
            rel++;
            if (stray_stop && rel == 1) chk({tag, ".stray_ignored"}, 64'(tdc_arm), 64'd1);
            if (!exp_to && rel == m) begin
                chk({tag, ".stop_disarm"}, 64'(tdc_arm), 64'd0);
                chk({tag, ".settle_ro"},   64'(ro_en),   64'd1);
            end
            if (res_valid) seen = 1'b1;
        end
        chk({tag, ".latency"}, 64'(rel), 64'(exp_rel));
        if (!seen) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end else begin
            chk({tag, ".coarse"},  res_coarse,          exp_coarse);
            chk({tag, ".sfine"},   64'(res_start_fine), 64'(exp_sf));
            chk({tag, ".efine"},   64'(res_stop_fine),  64'(exp_ef));
            chk({tag, ".timeout"}, 64'(res_timeout),    64'(exp_to));
            chk({tag, ".hold_ro"}, 64'(ro_en),          64'd0);
            if (bp_cyc > 0) begin
                meas_req = 1'b1;
                repeat (bp_cyc) tick();
                meas_req = 1'b0;
                chk({tag, ".bp_valid"},  64'(res_valid),  64'd1);
                chk({tag, ".bp_busy"},   64'(meas_busy),  64'd1);
                chk({tag, ".bp_coarse"}, res_coarse,      exp_coarse);
                chk({tag, ".bp_sfine"},  64'(res_start_fine), 64'(exp_sf));
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk_idle({tag, ".accepted"});
        end
        start_flag = 1'b0;
        stop_flag  = 1'b0;
        tick();
    endtask

    initial begin
        logic [63:0] rsc, rec;
        logic [7:0]  rsf, ref_f;
        int          mode, sdly, edly, bp;
        logic [15:0] rt;

        rst_n        = 1'b0;
        meas_req     = 1'b0;
        abort        = 1'b0;
        timeout_cyc  = '0;
        start_flag   = 1'b0;
        stop_flag    = 1'b0;
        start_coarse = '0;
        stop_coarse  = '0;
        start_fine   = '0;
        stop_fine    = '0;
        res_ready    = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset.timeout", 64'(res_timeout), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("reset.state", 64'(dbg_state), 64'(S_IDLE));

        // directed scenarios
        do_meas("normal",  64'd100, 64'd103, 8'd17, 8'd5, 3, 5, 16'd0, 1'b0, 0);
        do_meas("wrap",    64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 8'd200, 8'd3, 1, 6, 16'd0, 1'b0, 0);
        do_meas("tmo",     64'd50, 64'd60, 8'd9, 8'd9, 2, -1, 16'd20, 1'b0, 0);
        do_meas("tmo_win", 64'd1000, 64'd1234, 8'd44, 8'd88, 2, 17, 16'd20, 1'b0, 0);
        do_meas("tmo_late", 64'd1000, 64'd1234, 8'd44, 8'd88, 2, 18, 16'd20, 1'b0, 0);
        do_meas("same",    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0 + 64'd7,
                8'd1, 8'd2, 4, 0, 16'd0, 1'b0, 0);
        do_meas("stray",   64'd7, 64'd20, 8'd11, 8'd12, 3, 4, 16'd0, 1'b1, 0);
        do_meas("bp",      64'd300, 64'd250, 8'd77, 8'd66, 0, 3, 16'd0, 1'b0, 10);
        do_meas("fresh",   64'd5, 64'd6, 8'd255, 8'd0, 1, 1, 16'd0, 1'b0, 0);

        // abort while RUN
        timeout_cyc = '0;
        meas_req    = 1'b1;
        tick();
        meas_req = 1'b0;
        repeat (WARM) tick();
        start_flag   = 1'b1;
        start_coarse = 64'd10;
        tick();
        tick();
        chk("abort.pre_arm", 64'(tdc_arm), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort");
        stop_flag = 1'b1;
        repeat (6) tick();
        chk("abort.no_result", 64'(res_valid), 64'd0);
        chk("abort.stay_idle", 64'(meas_busy), 64'd0);
        start_flag = 1'b0;
        stop_flag  = 1'b0;
        tick();

        // reset asserted while SETTLE
        meas_req = 1'b1;
        tick();
        meas_req = 1'b0;
        repeat (WARM) tick();
        start_flag = 1'b1;
        stop_flag  = 1'b1;
        tick();
        chk("rst.settle_arm", 64'(tdc_arm), 64'd0);
        chk("rst.settle_ro",  64'(ro_en),   64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("rst.async");
        start_flag = 1'b0;
        stop_flag  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst.no_result", 64'(res_valid), 64'd0);
        chk("rst.stay_idle", 64'(meas_busy), 64'd0);

        // randomized measurements
        for (int i = 0; i < 10; i++) begin
            rsc   = {$urandom, $urandom};
            rec   = {$urandom, $urandom};
            rsf   = 8'($urandom);
            ref_f = 8'($urandom);
            mode  = $urandom_range(0, 2);
            sdly  = $urandom_range(0, 5);
            bp    = $urandom_range(0, 3);
            if (mode == 0) begin
                rt   = 16'd0;
                edly = $urandom_range(0, 15);
            end else if (mode == 1) begin
                rt   = 16'($urandom_range(5, 30));
                edly = $urandom_range(0, 30);
            end else begin
                rt   = 16'($urandom_range(3, 15));
                edly = -1;
            end
            do_meas($sformatf("rnd%0d", i), rsc, rec, rsf, ref_f, sdly, edly, rt, 1'b0, bp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rotdc_seq.md
# rotdc_seq

Measurement sequencer for the free-running ring-oscillator TDC core. Accepts a measurement request, powers and warms the ring, arms the core, and waits for the core's start and stop capture flags, with a timeout. It then computes the wrap-safe coarse interval and presents coarse plus both fine phase codes on a valid/ready result port. It sits between the host/CSR logic and the TDC core; calibration stays downstream in the digital domain.

## Interface
- COUNTER_LEN, 64: width of core coarse (ring-lap) counter snapshots and of the result
- FINE_W, 8: width of core fine phase codes (ring tap index)
- TIMEOUT_W, 16: width of timeout load value
- WARM_CYC, 8: cycles the ring runs before arming (≥1)
- SETTLE_CYC, 2: cycles after the stop flag before snapshots are sampled (≥1)

Ports:
- clk  in  1  FSM clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- meas_req  in  1  level; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE, no result
- timeout_cyc  in  TIMEOUT_W  ARMED+RUN cycle budget; 0 = no timeout
- meas_busy  out  1  high in every state except IDLE
- ro_en  out  1  ring oscillator enable
- tdc_arm  out  1  core arm; core captures start/stop only while high
- start_flag  in  1  core start-captured flag, already synchronised to clk
- stop_flag  in  1  core stop-captured flag, already synchronised to clk
- start_coarse / stop_coarse  in  COUNTER_LEN  core snapshots; stable once the flag is high
- start_fine / stop_fine  in  FINE_W  core fine snapshots
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_coarse  out  COUNTER_LEN  stop_coarse − start_coarse mod 2^COUNTER_LEN
- res_start_fine / res_stop_fine  out  FINE_W  fine codes passed through
- res_timeout  out  1  result is a timeout record

## Operation
- States: IDLE → WARM → ARMED → RUN → SETTLE → CAPTURE → HOLD → IDLE.
- IDLE: all outputs 0. meas_req=1 → WARM. Requests in any other state are ignored.
- WARM: ro_en=1 for WARM_CYC cycles → ARMED. Timeout counter loads timeout_cyc on exit.
- ARMED: ro_en=tdc_arm=1.
  - start_flag only → RUN.
  - start_flag and stop_flag together → SETTLE.
  - stop_flag without start_flag is ignored.
- RUN: stop_flag → SETTLE.
- Timeout: the counter decrements each cycle in ARMED and RUN. On reaching 0 with timeout_cyc≠0 → CAPTURE with timeout set. A stop_flag in the same cycle wins and goes to SETTLE with no timeout.
- SETTLE: tdc_arm=0, ro_en=1 for SETTLE_CYC cycles → CAPTURE.
- CAPTURE, one cycle: load result registers.
  - Normal capture: res_coarse = stop_coarse − start_coarse, COUNTER_LEN-bit modular; wraparound needs no special handling.
  - Timeout: res_coarse=0, fine codes=0, res_timeout=1.
  - → HOLD.
- HOLD: ro_en=0, res_valid=1, result held stable. res_ready=1 → IDLE with res_valid=0 next cycle.
- abort=1 in any state → IDLE next cycle; ro_en, tdc_arm and res_valid drop, and the result is discarded. abort has priority over every other transition.
- Reset mid-operation: asynchronous return to IDLE; all outputs 0 immediately.

## Timing
- Reset values: meas_busy, ro_en, tdc_arm, res_valid, res_timeout = 0; res_coarse and fine codes = 0.
- All outputs are registered.
- meas_req high at edge N → WARM, meas_busy=1 and ro_en=1 from N+1.
- tdc_arm=1 from N+1+WARM_CYC.
- stop_flag seen at edge M → tdc_arm=0 from M+1; res_valid=1 from M+SETTLE_CYC+2.
- Timeout budget: with timeout_cyc=T and no stop, CAPTURE is entered T cycles after ARMED is entered; res_valid follows 1 cycle later.
- res_valid stays high until a cycle with res_ready=1. Earliest next measurement: meas_req sampled the cycle after that handshake.

## Structure
- Package rotdc_pkg: state enum (7 states), default width localparams shared with the TDC core and CSR block.
- Sub-module rotdc_cycle_timer: one loadable down-counter, max(TIMEOUT_W, clog2 of WARM/SETTLE) bits, shared by the WARM, SETTLE and timeout intervals. Outputs a zero flag.

## Test plan
- Normal: WARM_CYC=8, SETTLE_CYC=2. Start at coarse 100, fine 17; stop at coarse 103, fine 5 → res_coarse=3, fines 17/5, res_timeout=0, res_valid 4 cycles after stop_flag.
- Wrap: start_coarse=2^64−2, stop_coarse=1 → res_coarse=3.
- Timeout: timeout_cyc=20, start but no stop → res_timeout=1, res_coarse=0, res_valid 21 cycles after ARMED entry. Repeat with stop_flag on the expiry cycle → normal result.
- Same-cycle start+stop in ARMED → SETTLE directly, res_coarse=stop−start; a stop-only pulse in ARMED is ignored.
- Backpressure: res_ready low for 10 cycles → result stable, meas_req ignored; accept → IDLE, next request starts a fresh WARM.
- abort in RUN and rst_n low in SETTLE → ro_en, tdc_arm, res_valid = 0 (next cycle / immediately); no result produced.
